// File: rtl/wb_scr_arbiter_pkg.sv
// Shared encodings and byte-lane helpers for the SCR1 IMEM/DMEM to Wishbone arbiter.
package wb_scr_arbiter_pkg;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_ERR  = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic       PORT_IMEM = 1'b0;
    localparam logic       PORT_DMEM = 1'b1;
    localparam logic [3:0] SEL_WORD  = 4'b1111;

    // The reserved width code is never a legal access, whatever the address.
    function automatic logic isMisaligned(input logic [1:0] width, input logic [1:0] addrLow);
        logic bad;
        bad = 1'b0;
        if (width == WIDTH_HALF) begin
            bad = addrLow[0];
        end else if (width == WIDTH_WORD) begin
            bad = (addrLow != 2'b00);
        end else if (width == WIDTH_RSVD) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [3:0] calcSel(input logic [1:0] width, input logic [1:0] addrLow);
        logic [3:0] sel;
        sel = 4'b0000;
        if (width == WIDTH_BYTE) begin
            sel = 4'b0001 << addrLow;
        end else if (width == WIDTH_HALF) begin
            sel = addrLow[1] ? 4'b1100 : 4'b0011;
        end else if (width == WIDTH_WORD) begin
            sel = SEL_WORD;
        end
        return sel;
    endfunction

    // Narrow write data arrives LSB-aligned; copy it onto every lane so the
    // slave finds it under whichever select bits are set.
    function automatic logic [31:0] replicateData(input logic [1:0] width, input logic [31:0] data);
        logic [31:0] rep;
        rep = data;
        if (width == WIDTH_BYTE) begin
            rep = {4{data[7:0]}};
        end else if (width == WIDTH_HALF) begin
            rep = {2{data[15:0]}};
        end
        return rep;
    endfunction

endpackage

// File: rtl/wb_scr_sel_gen.sv
// Combinational DMEM lane decode: byte selects, replicated write data and misalignment flag.
module wb_scr_sel_gen
    import wb_scr_arbiter_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  addrLow_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    always_comb begin
        sel_o        = calcSel(width_i, addrLow_i);
        wdata_o      = replicateData(width_i, wdata_i);
        misaligned_o = isMisaligned(width_i, addrLow_i);
    end

endmodule

// File: rtl/wb_scr_arbiter.sv
// Shares one Wishbone B4 classic master between the SCR1 IMEM and DMEM request ports.
// Define WB_SCR_ARB_RR_EN for round-robin arbitration; otherwise DMEM has fixed priority.
module wb_scr_arbiter
    import wb_scr_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic          imem_req_i,
    input  logic [AW-1:0] imem_addr_i,
    output logic          imem_req_ack_o,
    output logic [DW-1:0] imem_rdata_o,
    output logic [1:0]    imem_resp_o,

    input  logic          dmem_req_i,
    input  logic          dmem_cmd_i,
    input  logic [1:0]    dmem_width_i,
    input  logic [AW-1:0] dmem_addr_i,
    input  logic [DW-1:0] dmem_wdata_i,
    output logic          dmem_req_ack_o,
    output logic [DW-1:0] dmem_rdata_o,
    output logic [1:0]    dmem_resp_o,

    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    input  logic [DW-1:0] wbm_dat_i,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_stb_o,
    output logic          wbm_cyc_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i
);

    state_e        state_q;
    logic          owner_q;
    logic          cyc_q;
    logic          stb_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [3:0]    sel_q;
    resp_e         imemResp_q;
    resp_e         dmemResp_q;
    logic [DW-1:0] imemRdata_q;
    logic [DW-1:0] dmemRdata_q;

    logic          isIdle;
    logic          dmemHasPrio;
    logic          grantDmem;
    logic          grantImem;
    logic          busDone;
    logic [3:0]    dmemSel;
    logic [DW-1:0] dmemWdataRep;
    logic          dmemMisaligned;
    logic [AW-1:0] dmemAdr_d;
    logic [AW-1:0] imemAdr_d;
    logic          unusedImemLow;

    wb_scr_sel_gen u_selGen (
        .width_i      (dmem_width_i),
        .addrLow_i    (dmem_addr_i[1:0]),
        .wdata_i      (dmem_wdata_i),
        .sel_o        (dmemSel),
        .wdata_o      (dmemWdataRep),
        .misaligned_o (dmemMisaligned)
    );

    // Instruction fetches are always whole words, so the low address bits carry no information.
    assign unusedImemLow = ^imem_addr_i[1:0];

    assign isIdle    = (state_q == ST_IDLE);
    assign grantDmem = isIdle && dmem_req_i && (dmemHasPrio || !imem_req_i);
    assign grantImem = isIdle && imem_req_i && !grantDmem;
    assign busDone   = wbm_ack_i || wbm_err_i;
    assign dmemAdr_d = {dmem_addr_i[AW-1:2], 2'b00};
    assign imemAdr_d = {imem_addr_i[AW-1:2], 2'b00};

`ifdef WB_SCR_ARB_RR_EN
    logic prioDmem_q;
    logic prioDmem_d;

    // Whoever just won yields priority to the other port for the next tie.
    always_comb begin
        prioDmem_d = prioDmem_q;
        if (grantDmem) begin
            prioDmem_d = 1'b0;
        end else if (grantImem) begin
            prioDmem_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            prioDmem_q <= 1'b1;
        end else begin
            prioDmem_q <= prioDmem_d;
        end
    end

    assign dmemHasPrio = prioDmem_q;
`else
    assign dmemHasPrio = 1'b1;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= PORT_IMEM;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            imemResp_q  <= RESP_IDLE;
            dmemResp_q  <= RESP_IDLE;
            imemRdata_q <= '0;
            dmemRdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grantDmem) begin
                        owner_q <= PORT_DMEM;
                        // A misaligned access is refused locally without touching the bus.
                        if (dmemMisaligned) begin
                            dmemResp_q <= RESP_ERR;
                            state_q    <= ST_RESP;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= dmem_cmd_i;
                            adr_q   <= dmemAdr_d;
                            dat_q   <= dmemWdataRep;
                            sel_q   <= dmemSel;
                            state_q <= ST_BUS;
                        end
                    end else if (grantImem) begin
                        owner_q <= PORT_IMEM;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b0;
                        adr_q   <= imemAdr_d;
                        dat_q   <= '0;
                        sel_q   <= SEL_WORD;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (busDone) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_RESP;
                        if (owner_q == PORT_DMEM) begin
                            dmemResp_q <= wbm_err_i ? RESP_ERR : RESP_OK;
                            if (!we_q) begin
                                dmemRdata_q <= wbm_dat_i;
                            end
                        end else begin
                            imemResp_q  <= wbm_err_i ? RESP_ERR : RESP_OK;
                            imemRdata_q <= wbm_dat_i;
                        end
                    end
                end
                ST_RESP: begin
                    imemResp_q <= RESP_IDLE;
                    dmemResp_q <= RESP_IDLE;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req_ack_o = grantImem;
    assign dmem_req_ack_o = grantDmem;
    assign imem_rdata_o   = imemRdata_q;
    assign dmem_rdata_o   = dmemRdata_q;
    assign imem_resp_o    = imemResp_q;
    assign dmem_resp_o    = dmemResp_q;
    assign wbm_adr_o      = adr_q;
    assign wbm_dat_o      = dat_q;
    assign wbm_we_o       = we_q;
    assign wbm_sel_o      = sel_q;
    assign wbm_stb_o      = stb_q;
    assign wbm_cyc_o      = cyc_q;

endmodule

// File: tb/tb_wb_scr_arbiter.sv
// Randomized self-checking bench for wb_scr_arbiter against a transaction-level reference model.
// Honours WB_SCR_ARB_RR_EN in its arbitration model.
module tb_wb_scr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_req_i;
    logic [AW-1:0] imem_addr_i;
    logic          imem_req_ack_o;
    logic [DW-1:0] imem_rdata_o;
    logic [1:0]    imem_resp_o;
    logic          dmem_req_i;
    logic          dmem_cmd_i;
    logic [1:0]    dmem_width_i;
    logic [AW-1:0] dmem_addr_i;
    logic [DW-1:0] dmem_wdata_i;
    logic          dmem_req_ack_o;
    logic [DW-1:0] dmem_rdata_o;
    logic [1:0]    dmem_resp_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_stb_o;
    logic          wbm_cyc_o;
    logic          wbm_ack_i;
    logic          wbm_err_i;

    int          vectors = 0;
    int          miscompares = 0;
    bit          prioDmem;
    logic [31:0] expRdataI;
    logic [31:0] expRdataD;

    wb_scr_arbiter #(.AW(AW), .DW(DW)) dut (
        .wb_clk_i       (clock),
        .wb_rst_i       (reset),
        .imem_req_i     (imem_req_i),
        .imem_addr_i    (imem_addr_i),
        .imem_req_ack_o (imem_req_ack_o),
        .imem_rdata_o   (imem_rdata_o),
        .imem_resp_o    (imem_resp_o),
        .dmem_req_i     (dmem_req_i),
        .dmem_cmd_i     (dmem_cmd_i),
        .dmem_width_i   (dmem_width_i),
        .dmem_addr_i    (dmem_addr_i),
        .dmem_wdata_i   (dmem_wdata_i),
        .dmem_req_ack_o (dmem_req_ack_o),
        .dmem_rdata_o   (dmem_rdata_o),
        .dmem_resp_o    (dmem_resp_o),
        .wbm_adr_o      (wbm_adr_o),
        .wbm_dat_o      (wbm_dat_o),
        .wbm_dat_i      (wbm_dat_i),
        .wbm_we_o       (wbm_we_o),
        .wbm_sel_o      (wbm_sel_o),
        .wbm_stb_o      (wbm_stb_o),
        .wbm_cyc_o      (wbm_cyc_o),
        .wbm_ack_i      (wbm_ack_i),
        .wbm_err_i      (wbm_err_i)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_cyc"}, 32'(wbm_cyc_o), 32'd0);
        checkOutput({tag, "_stb"}, 32'(wbm_stb_o), 32'd0);
        checkOutput({tag, "_imem_resp"}, 32'(imem_resp_o), 32'd0);
        checkOutput({tag, "_dmem_resp"}, 32'(dmem_resp_o), 32'd0);
    endtask

    // One granted transaction, entered just after the edge that opens the IDLE cycle
    // in which this port is expected to win. Expected lanes come from plain arithmetic.
    task automatic serve(input bit isDmem, input int waits, input bit slaveErr, input bit bothFlags);
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] expAdr;
        logic [31:0] expDat;
        logic [3:0]  expSel;
        logic [31:0] rd;
        bit          expWe;
        bit          bad;
        w      = isDmem ? dmem_width_i : 2'd2;
        a      = isDmem ? dmem_addr_i : imem_addr_i;
        wd     = dmem_wdata_i;
        expWe  = isDmem && dmem_cmd_i;
        bad    = isDmem && ((w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0));
        expAdr = (a / 4) * 4;
        expDat = wd;
        expSel = 4'hF;
        rd     = 32'd0;
        if (w == 2'd0) begin
            expSel = 4'(1 << a[1:0]);
            expDat = {24'd0, wd[7:0]} * 32'h0101_0101;
        end else if (w == 2'd1) begin
            expSel = (a[1:0] >= 2) ? 4'hC : 4'h3;
            expDat = {16'd0, wd[15:0]} * 32'h0001_0001;
        end

        @(negedge clock);
        checkOutput("imem_req_ack", 32'(imem_req_ack_o), 32'(!isDmem));
        checkOutput("dmem_req_ack", 32'(dmem_req_ack_o), 32'(isDmem));
        prioDmem = !isDmem;
        nextCycle();
        if (isDmem) dmem_req_i = 1'b0;
        else imem_req_i = 1'b0;

        if (bad) begin
            @(negedge clock);
            checkOutput("misalign_resp", 32'(dmem_resp_o), 32'd2);
            checkOutput("misalign_cyc", 32'(wbm_cyc_o), 32'd0);
            checkOutput("misalign_imem_resp", 32'(imem_resp_o), 32'd0);
            checkOutput("misalign_no_ack", 32'(imem_req_ack_o | dmem_req_ack_o), 32'd0);
            checkOutput("misalign_rdata", dmem_rdata_o, expRdataD);
            nextCycle();
        end else begin
            for (int c = 0; c <= waits; c++) begin
                wbm_dat_i = $urandom;
                if (c == waits) begin
                    rd        = wbm_dat_i;
                    wbm_err_i = slaveErr;
                    wbm_ack_i = !slaveErr || bothFlags;
                end
                @(negedge clock);
                checkOutput("bus_cyc", 32'(wbm_cyc_o), 32'd1);
                checkOutput("bus_stb", 32'(wbm_stb_o), 32'd1);
                checkOutput("bus_we", 32'(wbm_we_o), 32'(expWe));
                checkOutput("bus_adr", wbm_adr_o, expAdr);
                checkOutput("bus_sel", 32'(wbm_sel_o), 32'(expSel));
                if (expWe) checkOutput("bus_dat", wbm_dat_o, expDat);
                checkOutput("bus_no_ack", 32'(imem_req_ack_o | dmem_req_ack_o), 32'd0);
                checkOutput("bus_no_resp", 32'(imem_resp_o | dmem_resp_o), 32'd0);
                nextCycle();
            end
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (!expWe) begin
                if (isDmem) expRdataD = rd;
                else expRdataI = rd;
            end
            @(negedge clock);
            checkOutput("done_cyc", 32'(wbm_cyc_o), 32'd0);
            checkOutput("done_stb", 32'(wbm_stb_o), 32'd0);
            checkOutput("done_we", 32'(wbm_we_o), 32'd0);
            checkOutput(isDmem ? "dmem_resp" : "imem_resp",
                        32'(isDmem ? dmem_resp_o : imem_resp_o), slaveErr ? 32'd2 : 32'd1);
            checkOutput("loser_resp", 32'(isDmem ? imem_resp_o : dmem_resp_o), 32'd0);
            checkOutput("imem_rdata", imem_rdata_o, expRdataI);
            checkOutput("dmem_rdata", dmem_rdata_o, expRdataD);
            nextCycle();
        end
    endtask

    // Present one or both requests at once and serve them in the order the arbitration rule implies.
    task automatic applyStimulus(input bit reqI, input bit reqD, input bit cmd, input logic [1:0] width,
                                 input logic [31:0] dAddr, input logic [31:0] wdata, input logic [31:0] iAddr,
                                 input int waitsI, input bit errI, input int waitsD, input bit errD);
        bit dFirst;
        imem_addr_i  = iAddr;
        dmem_cmd_i   = cmd;
        dmem_width_i = width;
        dmem_addr_i  = dAddr;
        dmem_wdata_i = wdata;
        imem_req_i   = reqI;
        dmem_req_i   = reqD;
`ifdef WB_SCR_ARB_RR_EN
        dFirst = prioDmem;
`else
        dFirst = 1'b1;
`endif
        if (reqI && reqD) begin
            if (dFirst) begin
                serve(1'b1, waitsD, errD, 1'b0);
                serve(1'b0, waitsI, errI, 1'b0);
            end else begin
                serve(1'b0, waitsI, errI, 1'b0);
                serve(1'b1, waitsD, errD, 1'b0);
            end
        end else if (reqD) begin
            serve(1'b1, waitsD, errD, errD && ($urandom_range(0, 1) == 1));
        end else if (reqI) begin
            serve(1'b0, waitsI, errI, errI && ($urandom_range(0, 1) == 1));
        end
        @(negedge clock);
        checkQuiet("idle");
        checkOutput("idle_no_ack", 32'(imem_req_ack_o | dmem_req_ack_o), 32'd0);
        nextCycle();
    endtask

    task automatic resetMidBus();
        dmem_cmd_i   = 1'b1;
        dmem_width_i = 2'd2;
        dmem_addr_i  = 32'h0000_3000;
        dmem_wdata_i = 32'h1234_5678;
        dmem_req_i   = 1'b1;
        @(negedge clock);
        checkOutput("rst_pre_ack", 32'(dmem_req_ack_o), 32'd1);
        nextCycle();
        dmem_req_i = 1'b0;
        @(negedge clock);
        checkOutput("rst_pre_cyc", 32'(wbm_cyc_o), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkQuiet("rst_async");
        checkOutput("rst_async_we", 32'(wbm_we_o), 32'd0);
        checkOutput("rst_async_sel", 32'(wbm_sel_o), 32'd0);
        checkOutput("rst_async_adr", wbm_adr_o, 32'd0);
        nextCycle();
        reset     = 1'b0;
        prioDmem  = 1'b1;
        expRdataI = 32'd0;
        expRdataD = 32'd0;
        @(negedge clock);
        checkQuiet("rst_after");
        nextCycle();
    endtask

    initial begin
        reset        = 1'b1;
        imem_req_i   = 1'b0;
        imem_addr_i  = '0;
        dmem_req_i   = 1'b0;
        dmem_cmd_i   = 1'b0;
        dmem_width_i = 2'd0;
        dmem_addr_i  = '0;
        dmem_wdata_i = '0;
        wbm_dat_i    = '0;
        wbm_ack_i    = 1'b0;
        wbm_err_i    = 1'b0;
        prioDmem     = 1'b1;
        expRdataI    = 32'd0;
        expRdataD    = 32'd0;

        @(negedge clock);
        checkQuiet("reset");
        checkOutput("reset_adr", wbm_adr_o, 32'd0);
        checkOutput("reset_rdata", imem_rdata_o | dmem_rdata_o, 32'd0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        $display("[TB] directed cases");
        applyStimulus(0, 1, 1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 0, 2, 0);
        applyStimulus(0, 1, 1, 2'd0, 32'h0000_1003, 32'h0000_005A, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2'd2, 32'h0000_2000, 32'h0, 32'h0000_0080, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 2'd2, 32'h0000_2004, 32'h0, 32'h0000_0084, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 2'd1, 32'h0000_2001, 32'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'd2, 32'h0, 32'h0, 32'h0000_0040, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 2'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 2'd3, 32'h0000_2000, 32'h0, 32'h0, 0, 0, 0, 0);

        resetMidBus();
        applyStimulus(1, 1, 0, 2'd2, 32'h0000_3000, 32'h0, 32'h0000_0100, 0, 0, 1, 0);

        $display("[TB] random cases");
        for (int n = 0; n < 60; n++) begin
            bit reqI;
            bit reqD;
            reqI = ($urandom_range(0, 1) == 1);
            reqD = ($urandom_range(0, 1) == 1);
            if (!reqI && !reqD) reqD = 1'b1;
            applyStimulus(reqI, reqD, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                          $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
